// File: rtl/delay_pkg.sv
// Shared types and default sizes for the microphone delay-line control slice.
package delay_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    RUN    = 2'd2,
    RETUNE = 2'd3
  } state_t;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_ADDR_W = 9;

endpackage

// File: rtl/tick_pulser.sv
// Turns a sample-rate strobe into a registered one-cycle pulse, gated by allow.
module tick_pulser (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic allow,
  output logic pulse
);

  always_ff @(posedge clk) begin
    if (rst) begin
      pulse <= 1'b0;
    end else begin
      pulse <= tick & allow;
    end
  end

endmodule

// File: rtl/delay_ctrl.sv
// Sequencer for the delay-line datapath: tick-to-pulse conversion, offset
// application on sample boundaries and fill tracking for output validity.
module delay_ctrl
  import delay_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             sample_tick,
  input  logic [WIDTH-1:0] offset_req,
  output logic             en,
  output logic             wr,
  output logic             rd,
  output logic [WIDTH-1:0] offset,
  output logic             out_valid,
  output logic [1:0]       state
);

  // The datapath zero-extends offset into the address counter.
  if (ADDR_W <= WIDTH) begin : g_width_check
    $error("delay_ctrl: ADDR_W must be greater than WIDTH");
  end

  state_t           cur_state;
  logic             pulse;
  logic             pulse_d;
  logic             allow;
  logic [WIDTH-1:0] fill_cnt;
  logic [WIDTH-1:0] pending_ofs;
  logic             ofs_change;
  logic             fill_eval;

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    if (v == {WIDTH{1'b1}}) begin
      return v;
    end else begin
      return v + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  endfunction

  assign allow      = ((cur_state == FILL) || (cur_state == RUN)) && !stop;
  // A tick always wins over a retune; the retune waits for a quiet cycle.
  assign ofs_change = !sample_tick && (pending_ofs != offset);
  assign fill_eval  = sample_tick || pulse_d;

  tick_pulser u_pulser (
    .clk   (clk),
    .rst   (rst),
    .tick  (sample_tick),
    .allow (allow),
    .pulse (pulse)
  );

  assign en    = pulse;
  assign wr    = pulse;
  assign rd    = pulse;
  assign state = cur_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state   <= IDLE;
      offset      <= {WIDTH{1'b0}};
      fill_cnt    <= {WIDTH{1'b0}};
      pending_ofs <= {WIDTH{1'b0}};
      out_valid   <= 1'b0;
      pulse_d     <= 1'b0;
    end else begin
      pending_ofs <= offset_req;
      pulse_d     <= pulse;
      if (stop) begin
        cur_state <= IDLE;
        out_valid <= 1'b0;
      end else begin
        case (cur_state)
          IDLE: begin
            out_valid <= 1'b0;
            if (start) begin
              cur_state <= FILL;
              offset    <= offset_req;
              fill_cnt  <= {WIDTH{1'b0}};
            end
          end
          FILL: begin
            out_valid <= 1'b0;
            if (pulse) begin
              fill_cnt <= sat_inc(fill_cnt);
            end
            if (ofs_change) begin
              cur_state <= RETUNE;
            end else if (fill_eval && (fill_cnt >= offset)) begin
              cur_state <= RUN;
            end
          end
          RUN: begin
            if (ofs_change) begin
              cur_state <= RETUNE;
              out_valid <= 1'b0;
            end else begin
              out_valid <= pulse;
            end
          end
          RETUNE: begin
            out_valid <= 1'b0;
            cur_state <= FILL;
            offset    <= offset_req;
            fill_cnt  <= {WIDTH{1'b0}};
          end
          default: begin
            out_valid <= 1'b0;
            cur_state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_delay_ctrl.sv
// Directed self-checking bench for delay_ctrl.
module tb_delay_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       sample_tick;
  logic [7:0] offset_req;
  logic       en;
  logic       wr;
  logic       rd;
  logic [7:0] offset;
  logic       out_valid;
  logic [1:0] state;

  int passed = 0;
  int total  = 0;

  delay_ctrl #(.WIDTH(8), .ADDR_W(9)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .sample_tick (sample_tick),
    .offset_req  (offset_req),
    .en          (en),
    .wr          (wr),
    .rd          (rd),
    .offset      (offset),
    .out_valid   (out_valid),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    total++; if ({en, wr, rd} !== 3'b000) $display("FAIL reset_pulse got=%b exp=000", {en, wr, rd}); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", out_valid); else passed++;
    total++; if (offset !== 8'd0) $display("FAIL reset_offset got=%0d exp=0", offset); else passed++;
    total++; if (state !== 2'd0) $display("FAIL reset_state got=%0d exp=0", state); else passed++;
  endtask

  task automatic test_fill_run();
    offset_req = 8'd4;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    total++; if (state !== 2'd1) $display("FAIL fill_enter_state got=%0d exp=1", state); else passed++;
    total++; if (offset !== 8'd4) $display("FAIL fill_enter_offset got=%0d exp=4", offset); else passed++;
    for (int k = 1; k <= 5; k++) begin
      repeat (5) step();
      sample_tick = 1'b1;
      step();
      sample_tick = 1'b0;
      total++; if ({en, wr, rd} !== 3'b111) $display("FAIL fill_pulse k=%0d got=%b exp=111", k, {en, wr, rd}); else passed++;
      step();
      total++; if (en !== 1'b0) $display("FAIL fill_pulse_width k=%0d got=%b exp=0", k, en); else passed++;
      total++; if (out_valid !== (k == 5)) $display("FAIL fill_valid k=%0d got=%b exp=%b", k, out_valid, (k == 5)); else passed++;
      step();
      total++; if (state !== ((k >= 4) ? 2'd2 : 2'd1)) $display("FAIL fill_state k=%0d got=%0d exp=%0d", k, state, ((k >= 4) ? 2 : 1)); else passed++;
    end
  endtask

  task automatic test_zero_offset();
    stop = 1'b1;
    step();
    stop = 1'b0;
    total++; if (state !== 2'd0) $display("FAIL zero_stop_state got=%0d exp=0", state); else passed++;
    offset_req = 8'd0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    total++; if (state !== 2'd1) $display("FAIL zero_fill_state got=%0d exp=1", state); else passed++;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    total++; if (en !== 1'b1) $display("FAIL zero_pulse got=%b exp=1", en); else passed++;
    total++; if (state !== 2'd2) $display("FAIL zero_run_state got=%0d exp=2", state); else passed++;
    step();
    total++; if (out_valid !== 1'b1) $display("FAIL zero_valid got=%b exp=1", out_valid); else passed++;
  endtask

  task automatic test_retune();
    stop = 1'b1;
    step();
    stop = 1'b0;
    offset_req = 8'd4;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sample_tick = 1'b1;
      step();
      sample_tick = 1'b0;
      step();
      step();
    end
    total++; if (state !== 2'd2) $display("FAIL retune_pre_state got=%0d exp=2", state); else passed++;
    sample_tick = 1'b1;
    offset_req  = 8'd10;
    step();
    sample_tick = 1'b0;
    total++; if (en !== 1'b1) $display("FAIL retune_tick_pulse got=%b exp=1", en); else passed++;
    total++; if (offset !== 8'd4) $display("FAIL retune_old_offset got=%0d exp=4", offset); else passed++;
    step();
    total++; if (state !== 2'd3) $display("FAIL retune_state got=%0d exp=3", state); else passed++;
    step();
    total++; if (state !== 2'd1) $display("FAIL retune_fill_state got=%0d exp=1", state); else passed++;
    total++; if (offset !== 8'd10) $display("FAIL retune_new_offset got=%0d exp=10", offset); else passed++;
    for (int i = 1; i <= 10; i++) begin
      sample_tick = 1'b1;
      step();
      sample_tick = 1'b0;
      total++; if (en !== 1'b1) $display("FAIL refill_pulse i=%0d got=%b exp=1", i, en); else passed++;
      step();
      total++; if (out_valid !== 1'b0) $display("FAIL refill_valid i=%0d got=%b exp=0", i, out_valid); else passed++;
      step();
      total++; if (state !== ((i == 10) ? 2'd2 : 2'd1)) $display("FAIL refill_state i=%0d got=%0d exp=%0d", i, state, ((i == 10) ? 2 : 1)); else passed++;
    end
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    step();
    total++; if (out_valid !== 1'b1) $display("FAIL refill_run_valid got=%b exp=1", out_valid); else passed++;
  endtask

  task automatic test_back_to_back();
    sample_tick = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      if (i == 3) sample_tick = 1'b0;
      total++; if ({en, wr, rd} !== 3'b111) $display("FAIL b2b_pulse i=%0d got=%b exp=111", i, {en, wr, rd}); else passed++;
    end
    step();
    total++; if (en !== 1'b0) $display("FAIL b2b_end got=%b exp=0", en); else passed++;
    total++; if (out_valid !== 1'b1) $display("FAIL b2b_valid got=%b exp=1", out_valid); else passed++;
    step();
    total++; if (out_valid !== 1'b0) $display("FAIL b2b_valid_end got=%b exp=0", out_valid); else passed++;
  endtask

  task automatic test_stop_start();
    stop  = 1'b1;
    start = 1'b1;
    step();
    stop  = 1'b0;
    start = 1'b0;
    total++; if (state !== 2'd0) $display("FAIL stopstart_state got=%0d exp=0", state); else passed++;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    total++; if (en !== 1'b0) $display("FAIL stopstart_no_pulse got=%b exp=0", en); else passed++;
    step();
    total++; if (out_valid !== 1'b0) $display("FAIL stopstart_valid got=%b exp=0", out_valid); else passed++;
  endtask

  task automatic test_rst_mid_pulse();
    offset_req = 8'd0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    total++; if (en !== 1'b1) $display("FAIL rst_pre_pulse got=%b exp=1", en); else passed++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if ({en, wr, rd, out_valid} !== 4'b0000) $display("FAIL rst_mid_outputs got=%b exp=0000", {en, wr, rd, out_valid}); else passed++;
    total++; if (offset !== 8'd0) $display("FAIL rst_mid_offset got=%0d exp=0", offset); else passed++;
    total++; if (state !== 2'd0) $display("FAIL rst_mid_state got=%0d exp=0", state); else passed++;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    total++; if (en !== 1'b0) $display("FAIL rst_tick_ignored got=%b exp=0", en); else passed++;
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    stop        = 1'b0;
    sample_tick = 1'b0;
    offset_req  = 8'd0;
    test_reset();
    test_fill_run();
    test_zero_offset();
    test_retune();
    test_back_to_back();
    test_stop_start();
    test_rst_mid_pulse();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
